// File: rtl/uart_cmd_pkg.sv
// Shared command-protocol constants and FSM state type for the UART register responder.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ   = 8'h52;  // 'R'

  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'
  localparam logic [7:0] RSP_BADOP = 8'h3F;  // '?'

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter: counts idle cycles while a frame is open and
// flags expiry once TIMEOUT cycles have passed without a byte.
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT));

  // Count while enabled, saturate at TIMEOUT, zero when idle or on a received byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || clear) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_reg_responder.sv
// UART command responder: parses 'W' addr data / 'R' addr frames, maintains an
// 8-bit register bank and returns one response byte per finished frame.
module uart_reg_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NREGS   = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_send,
  input  logic               tx_busy,
  output logic [8*NREGS-1:0] regs
);

  state_t     state, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] rsp_q, rsp_d;
  logic [7:0] rd_data;
  logic       rsp_fire;
  logic       send;
  logic       wr_en;
  logic       timer_en;
  logic       expired;
  logic       rx_in_range;
  logic       addr_in_range;

  assign rx_in_range   = (32'(rx_data) < NREGS);
  assign addr_in_range = (32'(addr_q) < NREGS);
  assign timer_en      = (state == ADDR) || (state == DATA);

  uart_frame_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (timer_en),
    .clear   (rx_valid),
    .expired (expired)
  );

  // Read mux: register selected by the byte currently on rx_data.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (8'(i) == rx_data) rd_data = regs[8*i +: 8];
    end
  end

  // Frame parser. A response produced with the transmitter free is sent on the
  // very next cycle, so RESP is only entered to wait out tx_busy.
  always_comb begin
    state_d  = state;
    op_d     = op_q;
    addr_d   = addr_q;
    rsp_d    = rsp_q;
    rsp_fire = 1'b0;
    wr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            op_d    = rx_data;
            state_d = ADDR;
          end else begin
            rsp_d    = RSP_BADOP;
            rsp_fire = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          addr_d = rx_data;
          if (op_q == OP_READ) begin
            rsp_d    = rx_in_range ? rd_data : RSP_ERR;
            rsp_fire = 1'b1;
          end else begin
            state_d = DATA;
          end
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wr_en    = addr_in_range;
          rsp_d    = addr_in_range ? RSP_OK : RSP_ERR;
          rsp_fire = 1'b1;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        // Bytes arriving while a response is pending are dropped.
      end
      default: state_d = IDLE;
    endcase
    if (rsp_fire) state_d = RESP;
    send = (rsp_fire || state == RESP) && !tx_busy;
    if (send) state_d = IDLE;
  end

  // State, response and register bank updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      rsp_q   <= '0;
      tx_data <= '0;
      tx_send <= 1'b0;
      regs    <= '0;
    end else begin
      state   <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rsp_q   <= rsp_d;
      tx_send <= send;
      if (send) tx_data <= rsp_d;
      if (wr_en) begin
        for (int unsigned i = 0; i < NREGS; i++) begin
          if (8'(i) == addr_q) regs[8*i +: 8] <= rx_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder against a frame-level reference model.
module tb_uart_reg_responder;

  localparam int unsigned NREGS   = 16;
  localparam int unsigned TIMEOUT = 20;

  logic               clk      = 1'b0;
  logic               rst_n    = 1'b0;
  logic [7:0]         rx_data  = 8'h00;
  logic               rx_valid = 1'b0;
  logic               tx_busy  = 1'b0;
  logic [7:0]         tx_data;
  logic               tx_send;
  logic [8*NREGS-1:0] regs;

  int tests = 0;
  int fails = 0;
  int sends_total = 0;
  logic prev_send = 1'b0;

  logic [7:0] model_regs [NREGS];

  always #5 clk = ~clk;

  uart_reg_responder #(
    .NREGS   (NREGS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy),
    .regs     (regs)
  );

  // Count transmit pulses and require each to last a single cycle.
  always @(negedge clk) begin
    if (tx_send === 1'b1) begin
      sends_total++;
      tests++;
      if (prev_send === 1'b1) begin
        fails++;
        $display("FAIL tx_send_single: tx_send high two cycles in a row, required single-cycle pulse");
      end
    end
    prev_send = tx_send;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion, required bench to finish");
    $fatal(1);
  end

  function automatic logic [8*NREGS-1:0] model_flat();
    logic [8*NREGS-1:0] f;
    for (int unsigned i = 0; i < NREGS; i++) f[8*i +: 8] = model_regs[i];
    return f;
  endfunction

  function automatic void model_clear();
    for (int unsigned i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
  endfunction

  // Expected response for a whole frame; applies the write to the model.
  function automatic logic [7:0] model_frame(input logic [7:0] op, input logic [7:0] addr,
                                             input logic [7:0] data);
    if (op == 8'h57) begin
      if (addr < NREGS) begin
        model_regs[addr[3:0]] = data;
        return 8'h4B;
      end
      return 8'h45;
    end
    if (op == 8'h52) return (addr < NREGS) ? model_regs[addr[3:0]] : 8'h45;
    return 8'h3F;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  // Sends a frame and returns what the DUT shows in the cycle after the last byte.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                           output logic sent, output logic [7:0] val,
                           output logic [8*NREGS-1:0] regs_at);
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      send_byte(addr);
      if (op == 8'h57) send_byte(data);
    end
    sent    = tx_send;
    val     = tx_data;
    regs_at = regs;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    tests++;
    if (regs !== '0) begin
      fails++;
      $display("FAIL reset_regs: got %h, required all zero", regs);
    end
    tests++;
    if (tx_send !== 1'b0) begin
      fails++;
      $display("FAIL reset_tx_send: got %b, required 0", tx_send);
    end
    tests++;
    if (tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_tx_data: got %h, required 00", tx_data);
    end
    rst_n = 1'b1;
    model_clear();
    step();
  endtask

  task automatic test_write_read();
    logic s;
    logic [7:0] v, e;
    logic [8*NREGS-1:0] r;
    e = model_frame(8'h57, 8'h03, 8'hA5);
    run_frame(8'h57, 8'h03, 8'hA5, s, v, r);
    tests++;
    if (s !== 1'b1 || v !== e) begin
      fails++;
      $display("FAIL write_resp: send=%b data=%h, required send=1 data=%h", s, v, e);
    end
    tests++;
    if (r !== model_flat()) begin
      fails++;
      $display("FAIL write_regs: got %h, required %h", r, model_flat());
    end
    e = model_frame(8'h52, 8'h03, 8'h00);
    run_frame(8'h52, 8'h03, 8'h00, s, v, r);
    tests++;
    if (s !== 1'b1 || v !== e) begin
      fails++;
      $display("FAIL read_resp: send=%b data=%h, required send=1 data=%h", s, v, e);
    end
  endtask

  task automatic test_out_of_range();
    logic s;
    logic [7:0] v, e;
    logic [8*NREGS-1:0] r;
    e = model_frame(8'h57, 8'h10, 8'hFF);
    run_frame(8'h57, 8'h10, 8'hFF, s, v, r);
    tests++;
    if (s !== 1'b1 || v !== e) begin
      fails++;
      $display("FAIL oor_write_resp: send=%b data=%h, required send=1 data=%h", s, v, e);
    end
    tests++;
    if (regs !== model_flat()) begin
      fails++;
      $display("FAIL oor_write_regs: got %h, required %h", regs, model_flat());
    end
    e = model_frame(8'h52, 8'hFF, 8'h00);
    run_frame(8'h52, 8'hFF, 8'h00, s, v, r);
    tests++;
    if (s !== 1'b1 || v !== e) begin
      fails++;
      $display("FAIL oor_read_resp: send=%b data=%h, required send=1 data=%h", s, v, e);
    end
  endtask

  task automatic test_bad_opcode();
    logic s;
    logic [7:0] v, e;
    logic [8*NREGS-1:0] r;
    int n0;
    n0 = sends_total;
    e = model_frame(8'h41, 8'h00, 8'h00);
    run_frame(8'h41, 8'h00, 8'h00, s, v, r);
    idle(3);
    tests++;
    if (s !== 1'b1 || v !== e) begin
      fails++;
      $display("FAIL badop_resp: send=%b data=%h, required send=1 data=%h", s, v, e);
    end
    tests++;
    if (sends_total - n0 !== 1) begin
      fails++;
      $display("FAIL badop_count: got %0d responses, required 1", sends_total - n0);
    end
    e = model_frame(8'h52, 8'h00, 8'h00);
    run_frame(8'h52, 8'h00, 8'h00, s, v, r);
    tests++;
    if (s !== 1'b1 || v !== e) begin
      fails++;
      $display("FAIL badop_next_read: send=%b data=%h, required send=1 data=%h", s, v, e);
    end
  endtask

  task automatic test_backpressure();
    logic s, bad;
    logic [7:0] v, e;
    logic [8*NREGS-1:0] r;
    int n0;
    n0 = sends_total;
    e = model_frame(8'h52, 8'h00, 8'h00);
    send_byte(8'h52);
    tx_busy = 1'b1;
    send_byte(8'h00);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_send !== 1'b0) bad = 1'b1;
      if (i == 10) send_byte(8'h57);
      else step();
    end
    tx_busy = 1'b0;
    if (tx_send !== 1'b0) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL bp_hold: tx_send rose while tx_busy=1, required 0");
    end
    step();
    tests++;
    if (tx_send !== 1'b1 || tx_data !== e) begin
      fails++;
      $display("FAIL bp_release: send=%b data=%h, required send=1 data=%h", tx_send, tx_data, e);
    end
    idle(3);
    tests++;
    if (sends_total - n0 !== 1) begin
      fails++;
      $display("FAIL bp_count: got %0d responses, required 1", sends_total - n0);
    end
    e = model_frame(8'h52, 8'h03, 8'h00);
    run_frame(8'h52, 8'h03, 8'h00, s, v, r);
    tests++;
    if (s !== 1'b1 || v !== e) begin
      fails++;
      $display("FAIL bp_dropped_byte: send=%b data=%h, required send=1 data=%h", s, v, e);
    end
  endtask

  task automatic test_timeout();
    logic s;
    logic [7:0] v, e;
    logic [8*NREGS-1:0] r;
    int n0;
    logic [7:0] dv [2];
    int gaps [2];
    n0 = sends_total;
    send_byte(8'h57);
    send_byte(8'h05);
    idle(TIMEOUT + 1);
    tests++;
    if (sends_total !== n0 || regs !== model_flat()) begin
      fails++;
      $display("FAIL to_abort: responses=%0d regs=%h, required 0 and %h",
               sends_total - n0, regs, model_flat());
    end
    e = model_frame(8'h52, 8'h05, 8'h00);
    run_frame(8'h52, 8'h05, 8'h00, s, v, r);
    tests++;
    if (s !== 1'b1 || v !== e) begin
      fails++;
      $display("FAIL to_read_after_abort: send=%b data=%h, required send=1 data=%h", s, v, e);
    end
    gaps[0] = TIMEOUT - 1; dv[0] = 8'h5A;
    gaps[1] = TIMEOUT;     dv[1] = 8'hC3;
    for (int k = 0; k < 2; k++) begin
      send_byte(8'h57);
      send_byte(8'h05);
      idle(gaps[k]);
      send_byte(dv[k]);
      s = tx_send;
      v = tx_data;
      e = model_frame(8'h57, 8'h05, dv[k]);
      step();
      tests++;
      if (s !== 1'b1 || v !== e || regs !== model_flat()) begin
        fails++;
        $display("FAIL to_gap%0d: send=%b data=%h regs=%h, required send=1 data=%h regs=%h",
                 gaps[k], s, v, regs, e, model_flat());
      end
    end
  endtask

  task automatic test_random();
    logic s;
    logic [7:0] v, e, op, addr, data;
    logic [8*NREGS-1:0] r;
    int unsigned sel;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) op = 8'h57;
      else if (sel < 8) op = 8'h52;
      else begin
        op = 8'($urandom_range(0, 255));
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
      end
      sel = $urandom_range(0, 7);
      if (sel == 0) addr = 8'($urandom_range(0, 255));
      else if (sel == 1) addr = 8'($urandom_range(15, 16));
      else addr = 8'($urandom_range(0, NREGS - 1));
      data = 8'($urandom_range(0, 255));
      e = model_frame(op, addr, data);
      run_frame(op, addr, data, s, v, r);
      tests++;
      if (s !== 1'b1 || v !== e) begin
        fails++;
        $display("FAIL rand_resp[%0d] op=%h addr=%h: send=%b data=%h, required send=1 data=%h",
                 n, op, addr, s, v, e);
      end
      tests++;
      if (r !== model_flat()) begin
        fails++;
        $display("FAIL rand_regs[%0d]: got %h, required %h", n, r, model_flat());
      end
      idle(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h57);
    send_byte(8'h02);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
    tests++;
    if (regs !== '0 || tx_data !== 8'h00 || tx_send !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: regs=%h tx_data=%h tx_send=%b, required 0/00/0",
               regs, tx_data, tx_send);
    end
    send_byte(8'h33);
    tests++;
    if (tx_send !== 1'b1 || tx_data !== 8'h3F) begin
      fails++;
      $display("FAIL midreset_opcode: send=%b data=%h, required send=1 data=3f", tx_send, tx_data);
    end
    step();
    tests++;
    if (regs !== model_flat()) begin
      fails++;
      $display("FAIL midreset_regs: got %h, required %h", regs, model_flat());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_out_of_range();
    test_bad_opcode();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_midframe();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
